// File: rtl/alu_sequencer.sv
// Instruction sequencer for the ALU/register block: buffers 8-bit ALU instructions in a
// 2-entry FIFO and expands each into a SETUP/EXEC control sequence. Optional macro:
// ALU_SEQ_CARRY_EN routes fout[0] into cin for ADC/SBC and rotate-through-carry.
module alu_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] ins,
    input  logic       ins_valid,
    output logic       ins_ready,
    input  logic [3:0] fout,
    output logic [3:0] outctl,
    output logic [3:0] loadctl,
    output logic [1:0] arg_l,
    output logic [2:0] arg_r,
    output logic       alt,
    output logic       calcfn,
    output logic       cin,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {StIdle, StSetup, StExec} state_e;

    typedef enum logic [2:0] {
        OpMov, OpAdd, OpSub, OpLogic, OpXor, OpShift, OpCmp, OpFlg
    } op_e;

    localparam logic [3:0] CodeAddSub = 4'h2;
    localparam logic [3:0] CodeFlags  = 4'h4;
    localparam logic [3:0] CodeAndOr  = 4'h6;
    localparam logic [3:0] CodeShift  = 4'h7;
    localparam logic [3:0] CodeXorNot = 4'hA;
    localparam logic [3:0] CodeIdle   = 4'hF;
    localparam logic [3:0] LoadFlags  = 4'h7;

    // A=0, B=1, C=8, D=9
    function automatic logic [3:0] reg_code(input logic [1:0] r);
        return {r[1], 2'b00, r[0]};
    endfunction

    state_e     state_q, state_d;
    logic [7:0] mem_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       ready_q, ready_d;
    logic [3:0] outctl_q, outctl_d;
    logic [3:0] loadctl_q, loadctl_d;
    logic [1:0] arg_l_q, arg_l_d;
    logic [2:0] arg_r_q, arg_r_d;
    logic       alt_q, alt_d;
    logic       calcfn_q, calcfn_d;
    logic       cin_q, cin_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       push;
    logic       pop;
    logic [7:0] head;
    op_e        op;
    logic [1:0] dst;
    logic [1:0] src;
    logic       mod;
    logic [3:0] exec_out;
    logic [3:0] exec_load;
    logic       op_alt;
    logic       op_calc;
    logic       carry_use;
    logic       setup_cin;

    assign push = ins_valid && ready_q;
    assign pop  = (state_q == StExec);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (count_q != 2'd0) state_d = StSetup;
            StSetup: state_d = StExec;
            // Only an entry already buffered behind the head chains straight into SETUP.
            StExec:  state_d = (count_q > 2'd1) ? StSetup : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        ready_d  = (count_d != 2'd2);
    end

    // Instruction for the upcoming cycle; stays put from SETUP through EXEC.
    assign head = mem_q[rd_ptr_d];
    assign op   = op_e'(head[7:5]);
    assign dst  = head[4:3];
    assign mod  = head[2];
    assign src  = head[1:0];

    always_comb begin
        exec_out  = CodeIdle;
        exec_load = CodeIdle;
        op_alt    = 1'b0;
        op_calc   = 1'b0;
        carry_use = 1'b0;
        unique case (op)
            OpMov: begin
                exec_out  = reg_code(src);
                exec_load = reg_code(dst);
            end
            OpAdd: begin
                exec_out  = CodeAddSub;
                exec_load = reg_code(dst);
                op_calc   = 1'b1;
                carry_use = mod;
            end
            OpSub: begin
                exec_out  = CodeAddSub;
                exec_load = reg_code(dst);
                op_alt    = 1'b1;
                op_calc   = 1'b1;
                carry_use = mod;
            end
            OpLogic: begin
                exec_out  = CodeAndOr;
                exec_load = reg_code(dst);
                op_alt    = mod;
                op_calc   = 1'b1;
            end
            OpXor: begin
                exec_out  = CodeXorNot;
                exec_load = reg_code(dst);
                op_alt    = mod;
                op_calc   = 1'b1;
            end
            OpShift: begin
                exec_out  = CodeShift;
                exec_load = reg_code(dst);
                op_alt    = mod;
                op_calc   = 1'b1;
                carry_use = ~mod;
            end
            OpCmp: begin
                exec_out  = CodeAddSub;
                exec_load = CodeIdle;
                op_alt    = 1'b1;
                op_calc   = 1'b1;
            end
            OpFlg: begin
                if (mod) begin
                    exec_out  = reg_code(src);
                    exec_load = LoadFlags;
                end else begin
                    exec_out  = CodeFlags;
                    exec_load = reg_code(dst);
                end
            end
            default: begin
                exec_out  = CodeIdle;
                exec_load = CodeIdle;
            end
        endcase
    end

`ifdef ALU_SEQ_CARRY_EN
    assign setup_cin = carry_use & fout[0];
`else
    logic unused_inputs;
    assign unused_inputs = carry_use ^ (^fout);
    assign setup_cin     = 1'b0;
`endif

    always_comb begin
        outctl_d  = CodeIdle;
        loadctl_d = CodeIdle;
        arg_l_d   = 2'd0;
        arg_r_d   = 3'd0;
        alt_d     = 1'b0;
        calcfn_d  = 1'b1;
        cin_d     = 1'b0;
        if (state_d != StIdle) begin
            arg_l_d = dst;
            arg_r_d = {1'b0, src};
            alt_d   = op_alt;
            // Carry is captured entering SETUP and held through EXEC.
            cin_d   = (state_d == StSetup) ? setup_cin : cin_q;
        end
        if (state_d == StExec) begin
            outctl_d  = exec_out;
            loadctl_d = exec_load;
            calcfn_d  = ~op_calc;
        end
        busy_d = (state_d != StIdle) || (count_d != 2'd0);
        done_d = (state_d == StExec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            count_q   <= 2'd0;
            ready_q   <= 1'b1;
            outctl_q  <= CodeIdle;
            loadctl_q <= CodeIdle;
            arg_l_q   <= 2'd0;
            arg_r_q   <= 3'd0;
            alt_q     <= 1'b0;
            calcfn_q  <= 1'b1;
            cin_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ready_q   <= ready_d;
            outctl_q  <= outctl_d;
            loadctl_q <= loadctl_d;
            arg_l_q   <= arg_l_d;
            arg_r_q   <= arg_r_d;
            alt_q     <= alt_d;
            calcfn_q  <= calcfn_d;
            cin_q     <= cin_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ins;
        end
    end

    assign ins_ready = ready_q;
    assign outctl    = outctl_q;
    assign loadctl   = loadctl_q;
    assign arg_l     = arg_l_q;
    assign arg_r     = arg_r_q;
    assign alt       = alt_q;
    assign calcfn    = calcfn_q;
    assign cin       = cin_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
